ioctl_mem_arbiter: RTL

//  Sequences the single shared memory port between the ioctl download stream (data_io output) and core

---
 rtl/ioctl_arb_pkg.sv | 21 ++
 rtl/ioctl_wr_slot.sv | 69 ++++++
 rtl/ioctl_mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_arb_pkg.sv
// Shared types and constants for the ioctl / core memory-port arbiter.
// Each download slot owns a 1 MiB window; slot n starts at n << 20.
package ioctl_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } arb_state_e;

  localparam int NREGIONS_DEF = 4;

  // Bases are stored 32 bits wide; the arbiter sizes them to its address width.
  localparam logic [15:0][31:0] REGION_BASE = {
    32'h0F00000, 32'h0E00000, 32'h0D00000, 32'h0C00000,
    32'h0B00000, 32'h0A00000, 32'h0900000, 32'h0800000,
    32'h0700000, 32'h0600000, 32'h0500000, 32'h0400000,
    32'h0300000, 32'h0200000, 32'h0100000, 32'h0000000
  };

endpackage

// File: rtl/ioctl_wr_slot.sv
// Single-entry ioctl write buffer with a sticky overflow flag.
// A load in the same cycle as a drain refills the entry, so it stays full.
module ioctl_wr_slot #(
  parameter int AW = 27,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic          clr_ovf_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          accept_o,
  output logic          overflow_o
);

  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          accept, drop;

  assign accept = load_i && (!full_q || drain_i);
  assign drop   = load_i && full_q && !drain_i;

  always_comb begin
    full_d = full_q;
    ovf_d  = ovf_q;
    if (accept) begin
      full_d = 1'b1;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
    // A drop in the same cycle as the clear still counts as an overflow.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q <= addr_i;
      data_q <= data_i;
    end
  end

  assign full_o     = full_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign accept_o   = accept;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ioctl_mem_arbiter.sv
// Shares one memory port between ioctl download writes and core reads, and holds
// the core in reset across downloads. Define IOCTL_ARB_CHECKSUM_EN for dl_checksum.
module ioctl_mem_arbiter
  import ioctl_arb_pkg::*;
#(
  parameter int AW         = 27,
  parameter int DW         = 8,
  parameter int NREGIONS   = NREGIONS_DEF,
  parameter int RESET_HOLD = 16
) (
  input  logic          clk_memory,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [15:0]   ioctl_index,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_data,
  input  logic          core_rd,
  input  logic [AW-1:0] core_addr,
  output logic          core_rd_ack,
  output logic [DW-1:0] core_rd_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_reset,
  output logic          wr_overflow,
  output logic          dl_done
`ifdef IOCTL_ARB_CHECKSUM_EN
  ,
  output logic [31:0]   dl_checksum
`endif
);

  localparam int              CNT_W     = $clog2(RESET_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RESET_HOLD);
  localparam logic [15:0]     NREG_LIM  = 16'(NREGIONS);

  arb_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rd_ack_q, rd_ack_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic             dl_q;
  logic             core_reset_q, core_reset_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             dl_seen_q, dl_seen_d;
  logic             dl_done_q, dl_done_d;

  logic          dl_rise, idx_ok, launch_wr, rel_ok;
  logic [AW-1:0] wr_addr;
  logic          slot_full, slot_accept, slot_ovf;
  logic [AW-1:0] slot_addr;
  logic [DW-1:0] slot_data;

  assign dl_rise = ioctl_download && !dl_q;
  assign idx_ok  = ioctl_index < NREG_LIM;
  // Relocation wraps modulo 2^AW.
  assign wr_addr = AW'(REGION_BASE[ioctl_index[3:0]]) + ioctl_addr;

  ioctl_wr_slot #(
    .AW(AW),
    .DW(DW)
  ) u_slot (
    .clk_i      (clk_memory),
    .rst_ni     (reset_n),
    .load_i     (ioctl_wr && idx_ok),
    .drain_i    (launch_wr),
    .clr_ovf_i  (dl_rise),
    .addr_i     (wr_addr),
    .data_i     (ioctl_data),
    .full_o     (slot_full),
    .addr_o     (slot_addr),
    .data_o     (slot_data),
    .accept_o   (slot_accept),
    .overflow_o (slot_ovf)
  );

  // Writes beat reads; a read is not re-launched in its own ack cycle while
  // the core is still holding core_rd high.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_ack_d    = 1'b0;
    rd_data_d   = rd_data_q;
    launch_wr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot_full) begin
          state_d     = ST_WR;
          launch_wr   = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = slot_addr;
          mem_wdata_d = slot_data;
        end else if (core_rd && !core_reset_q && !rd_ack_q) begin
          state_d    = ST_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = core_addr;
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          rd_ack_d  = 1'b1;
          rd_data_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_ack_q    <= rd_ack_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Hold-off only counts once the download has ended and the last write drained.
  assign rel_ok = core_reset_q && !ioctl_download && !slot_full && (state_q == ST_IDLE);

  always_comb begin
    core_reset_d = core_reset_q;
    hold_d       = hold_q;
    dl_seen_d    = dl_seen_q;
    dl_done_d    = 1'b0;
    if (dl_rise) begin
      core_reset_d = 1'b1;
      hold_d       = HOLD_INIT;
      dl_seen_d    = 1'b1;
    end else if (rel_ok) begin
      if (hold_q <= CNT_W'(1)) begin
        core_reset_d = 1'b0;
        dl_done_d    = dl_seen_q;
        dl_seen_d    = 1'b0;
      end else begin
        hold_d = hold_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      dl_q         <= 1'b0;
      core_reset_q <= 1'b1;
      hold_q       <= HOLD_INIT;
      dl_seen_q    <= 1'b0;
      dl_done_q    <= 1'b0;
    end else begin
      dl_q         <= ioctl_download;
      core_reset_q <= core_reset_d;
      hold_q       <= hold_d;
      dl_seen_q    <= dl_seen_d;
      dl_done_q    <= dl_done_d;
    end
  end

`ifdef IOCTL_ARB_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = dl_rise ? 32'd0 : csum_q;
    if (slot_accept) begin
      csum_d = csum_d + 32'(ioctl_data);
    end
  end

  always_ff @(posedge clk_memory or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 32'd0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign dl_checksum = csum_q;
`else
  logic unused_accept;
  assign unused_accept = slot_accept;
`endif

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_rd_ack  = rd_ack_q;
  assign core_rd_data = rd_data_q;
  assign core_reset   = core_reset_q;
  assign wr_overflow  = slot_ovf;
  assign dl_done      = dl_done_q;

endmodule
